// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full adder used LSB-first, one bit per clock,
// with a start/ready/done handshake and registered parallel result.

module structuralFullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    logic w_axb;
    logic w_ab;
    logic w_cxab;

    xor u_x1 (w_axb, i_a, i_b);
    xor u_x2 (o_sum, w_axb, i_cin);
    and u_a1 (w_ab, i_a, i_b);
    and u_a2 (w_cxab, w_axb, i_cin);
    or  u_o1 (o_cout, w_ab, w_cxab);
endmodule

// state | meaning
// IDLE  | waiting for start; ready=1
// RUN   | one operand bit per clock through the full adder; busy=1
// DONE  | result registers updated on entry; done=1 for this one cycle
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carryin,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carryout,
    output logic             o_overflow
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_ps;
    logic             r_cy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_carryout;
    logic             r_overflow;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_ps_nxt;

    structuralFullAdder u_fa (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_cin  (r_cy),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_LAST);
    assign w_ps_nxt = {w_fa_sum, r_ps[WIDTH-1:1]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state == S_IDLE);
        o_busy  = (r_state == S_RUN);
        o_done  = (r_state == S_DONE);
    end

    // Result registers move only on the last-bit edge, so they stay stable through RUN.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sa       <= '0;
            r_sb       <= '0;
            r_ps       <= '0;
            r_cy       <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= i_a;
            r_sb  <= i_b;
            r_cy  <= i_carryin;
            r_cnt <= '0;
            r_ps  <= '0;
        end else if (r_state == S_RUN) begin
            r_sa <= r_sa >> 1;
            r_sb <= r_sb >> 1;
            r_ps <= w_ps_nxt;
            r_cy <= w_fa_cout;
            if (w_last) begin
                r_sum      <= w_ps_nxt;
                r_carryout <= w_fa_cout;
                r_overflow <= r_cy ^ w_fa_cout;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sum      = r_sum;
    assign o_carryout = r_carryout;
    assign o_overflow = r_overflow;
endmodule
